// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Purpose  : Shared CPU register-file constants and controller state encoding.
// Revision : 1.0
// ============================================================================
package regfile_mp_pkg;

  localparam int c_def_width = 32;
  localparam int c_def_depth = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage : regfile_mp_pkg
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rdport
// Purpose  : One read port: zero-register / write-bypass / stored-value mux.
// Revision : 1.0
// ============================================================================
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = c_def_width,
  parameter int AW       = $clog2(c_def_depth),
  parameter int ZERO_REG = 1
) (
  input  logic             force_zero,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] stored,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata
);

  logic w_zero_reg_hit;
  logic w_hit0;
  logic w_hit1;

  assign w_zero_reg_hit = (ZERO_REG != 0) && (raddr == '0);
  assign w_hit0         = we0 && (waddr0 == raddr);
  assign w_hit1         = we1 && (waddr1 == raddr);

  // Port 1 is checked before port 0 so a colliding pair forwards the winner.
  always_comb begin
    rdata = stored;
    if (force_zero || w_zero_reg_hit) begin
      rdata = '0;
    end else if (w_hit1) begin
      rdata = wdata1;
    end else if (w_hit0) begin
      rdata = wdata0;
    end
  end

endmodule : regfile_rdport
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read, dual-write register file with sweep-based clearing.
// Revision : 1.0
// ============================================================================
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int WIDTH    = c_def_width,
  parameter  int DEPTH    = c_def_depth,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr0,
  input  logic [AW-1:0]          waddr1,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic [WIDTH-1:0]       wdata1,
  input  logic                   clear_req,
  output logic                   ready
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (NREAD < 1) || (NREAD > 4))
  begin : g_bad_params
    $error("regfile_mp: illegal DEPTH or NREAD");
  end

  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_run;
  logic w_wr_ok;
  logic w_we0;
  logic w_we1;

  // ---------------------------------------------------------------------------
  // Clear/run controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      CLEAR: begin
        if (clear_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_last) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign w_run = (r_state == RUN);
  assign ready = w_run;

  // ---------------------------------------------------------------------------
  // Write qualification: only in RUN, never alongside clear_req, and never to
  // the hardwired zero register.
  // ---------------------------------------------------------------------------
  assign w_wr_ok = w_run && !clear_req;
  assign w_we0   = w_wr_ok && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_we1   = w_wr_ok && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Storage has no reset so it can map onto RAM/LUT primitives.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_we0) begin
        r_mem[waddr0] <= wdata0;
      end
      if (w_we1) begin
        r_mem[waddr1] <= wdata1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NREAD; k++) begin : g_rdport
    logic [AW-1:0] w_addr;
    assign w_addr = raddr[k*AW +: AW];

    regfile_rdport #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .force_zero (!w_run),
      .raddr      (w_addr),
      .stored     (r_mem[w_addr]),
      .we0        (w_we0),
      .waddr0     (waddr0),
      .wdata0     (wdata0),
      .we1        (w_we1),
      .waddr1     (waddr1),
      .wdata1     (wdata1),
      .rdata      (rdata[k*WIDTH +: WIDTH])
    );
  end

endmodule : regfile_mp
`default_nettype wire
